fir_coeff_sample_ctrl: RTL
==========================

Name: fir_coeff_sample_ctrl

Overview:
Control front end for the transposed FIR MAC chain.
- Generates the 300 kHz sample strobe from the 12 MHz clock.
- Registers the 3-bit filter input once per sample.
- Holds a double-buffered bank of ten signed 16-bit coefficients. A host loads the bank over a simple chip-select/write-enable bus.
- Commits new coefficients to the MAC chain only on a sample boundary, so a running filter never sees a partially updated coefficient set.

Parameters:
SAMPLE_DIV, 40, clock cycles per sample strobe (12 MHz / 300 kHz).
COEFF_W, 16, coefficient and bus data width.

Ports:
iClk_12M  input  1  system clock, 12 MHz.
iRsn  input  1  synchronous reset, active-low.
iCoeffUpdateFlag  input  1  host request: 1 = coefficient load in progress.
iCsn  input  1  bus chip select, active-low.
iWrn  input  1  bus write enable, active-low; 1 = read.
iAddr  input  4  coefficient index 0..9; 10..15 unmapped.
iWrDt  input  16  write data, signed coefficient.
oRdDt  output  16  read data from the shadow bank.
iFirInRaw  input  3  signed raw sample from the input source.
oEnSample_300k  output  1  one-cycle sample strobe.
oFirIn  output  3  signed registered sample to the MAC chain.
oCoeff1..oCoeff10  output  16 each  signed active coefficients to the MAC chain.
oBusy  output  1  1 while the FSM is not IDLE.

Behaviour:
Reset (iRsn=0 at a clock edge):
- Sample counter, shadow bank, active bank, oRdDt, oFirIn, oEnSample_300k all 0; FSM goes to IDLE.
- Reset asserted mid-load discards both banks.

Sample strobe:
- Counter runs 0..SAMPLE_DIV-1 and wraps to 0.
- oEnSample_300k is registered and equals 1 for exactly the one cycle in which the counter equals SAMPLE_DIV-1.
- Result: one pulse every 40 cycles; the first pulse is in the 40th cycle after reset release.
- The counter is free-running and unaffected by the FSM or the bus.

Sample capture:
- On the edge where the counter equals SAMPLE_DIV-1:
  - state IDLE: oFirIn <= iFirInRaw.
  - any other state: oFirIn <= 0 (input muted during update).
- oFirIn holds between strobes.
- oFirIn becomes valid in the same cycle that oEnSample_300k is high.

FSM (registered state; decisions use current state):
- IDLE: iCoeffUpdateFlag=1 -> LOAD.
- LOAD: iCoeffUpdateFlag=0 -> PEND.
- PEND: iCoeffUpdateFlag=1 -> LOAD, with no commit. This takes priority even on a strobe cycle.
- PEND: otherwise, on a strobe cycle -> IDLE, and active[0..9] <= shadow[0..9] at the same edge.
- The commit is atomic: all ten coefficients change on one edge.
- oBusy = (state != IDLE).

Bus:
- Write: iCsn=0, iWrn=0, state==LOAD, iAddr<=9 -> shadow[iAddr] <= iWrDt.
  - A write in the cycle iCoeffUpdateFlag falls is accepted, because state is still LOAD.
  - Writes in IDLE or PEND are ignored.
  - Writes to addresses 10..15 are ignored.
- Read: iCsn=0, iWrn=1 -> oRdDt <= shadow[iAddr] on the next edge; addresses 10..15 return 0.
- When iCsn=1 or on a write, oRdDt <= 0.
- Reads are allowed in any state.

Coefficient outputs:
- oCoeffN = active[N-1], driven straight from registers with no combinational path from the bus.
- Coefficients change only on a commit edge, which is a strobe edge.
- The MAC chain therefore sees the new set starting with the sample captured at that strobe.

Test Plan:
1. Reset release, idle for 200 cycles -> oEnSample_300k high at cycles 40, 80, 120, 160, 200 (one cycle each); all oCoeff=0; oBusy=0.
2. With iFirInRaw=3'sb011 held, reach a strobe -> oFirIn=3 from the strobe cycle on; change iFirInRaw to -2 mid-period -> oFirIn stays 3 until the next strobe, then becomes -2.
3. Raise the flag, write addr0..9 with 0x0100, 0xFF00, ..., 0x7FFF, drop the flag at cycle 15 of the period -> oBusy=1; oCoeff unchanged until the next strobe; at that edge all ten update together; oBusy=0 the cycle after; oFirIn=0 for strobes taken during LOAD/PEND.
4. Write with the flag low (addr3=0x1234), then read addr3 -> readback is the old shadow value, not 0x1234; read addr12 -> 0; write addr12 in LOAD -> no shadow change.
5. Enter PEND and re-raise the flag in the exact strobe cycle -> no commit, state LOAD; drop the flag again -> commit at the following strobe.
6. Assert iRsn=0 for one cycle in LOAD after five writes -> shadow, active, and oFirIn are all 0; state IDLE; the counter restarts and the strobe arrives 40 cycles after release.

Source files
------------

// File: rtl/fir_coeff_sample_ctrl.sv
// Sample-strobe generator, input sample register and double-buffered coefficient
// bank feeding the transposed FIR MAC chain.
module fir_coeff_sample_ctrl #(
   parameter int SAMPLE_DIV = 40,
   parameter int COEFF_W    = 16
) (
   input  logic                      iClk_12M,
   input  logic                      iRsn,
   input  logic                      iCoeffUpdateFlag,
   input  logic                      iCsn,
   input  logic                      iWrn,
   input  logic [3:0]                iAddr,
   input  logic signed [COEFF_W-1:0] iWrDt,
   output logic [COEFF_W-1:0]        oRdDt,
   input  logic signed [2:0]         iFirInRaw,
   output logic                      oEnSample_300k,
   output logic signed [2:0]         oFirIn,
   output logic signed [COEFF_W-1:0] oCoeff1,
   output logic signed [COEFF_W-1:0] oCoeff2,
   output logic signed [COEFF_W-1:0] oCoeff3,
   output logic signed [COEFF_W-1:0] oCoeff4,
   output logic signed [COEFF_W-1:0] oCoeff5,
   output logic signed [COEFF_W-1:0] oCoeff6,
   output logic signed [COEFF_W-1:0] oCoeff7,
   output logic signed [COEFF_W-1:0] oCoeff8,
   output logic signed [COEFF_W-1:0] oCoeff9,
   output logic signed [COEFF_W-1:0] oCoeff10,
   output logic                      oBusy
);

   localparam int NUM_COEFF = 10;
   localparam int CNT_W     = $clog2(SAMPLE_DIV);

   typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

   state_t             state, state_nxt;
   logic               commit;
   logic               strobe_edge;
   logic [CNT_W-1:0]   cnt;
   logic [COEFF_W-1:0] shadow [NUM_COEFF];
   logic [COEFF_W-1:0] active [NUM_COEFF];
   logic               addr_ok;

   // The strobe edge is the edge that moves the counter onto SAMPLE_DIV-1, so the
   // strobe, the captured sample and a committed bank all appear in the same cycle.
   assign strobe_edge = (cnt == CNT_W'(SAMPLE_DIV - 2));
   assign addr_ok     = (iAddr < 4'(NUM_COEFF));

   always_ff @(posedge iClk_12M) begin
      if (!iRsn) begin
         cnt            <= '0;
         oEnSample_300k <= 1'b0;
         oFirIn         <= '0;
      end else begin
         cnt            <= (cnt == CNT_W'(SAMPLE_DIV - 1)) ? '0 : cnt + 1'b1;
         oEnSample_300k <= strobe_edge;
         if (strobe_edge)
            oFirIn <= (state == IDLE) ? iFirInRaw : 3'sd0;
      end
   end

   always_ff @(posedge iClk_12M) begin
      if (!iRsn) state <= IDLE;
      else       state <= state_nxt;
   end

   // A re-raised flag in PEND wins over a coincident strobe: no commit that sample.
   always_comb begin
      state_nxt = state;
      commit    = 1'b0;
      case (state)
         IDLE: if (iCoeffUpdateFlag) state_nxt = LOAD;
         LOAD: if (!iCoeffUpdateFlag) state_nxt = PEND;
         PEND: begin
            if (iCoeffUpdateFlag) begin
               state_nxt = LOAD;
            end else if (strobe_edge) begin
               state_nxt = IDLE;
               commit    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge iClk_12M) begin
      if (!iRsn) begin
         for (int i = 0; i < NUM_COEFF; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         oRdDt <= '0;
      end else begin
         if (!iCsn && !iWrn && state == LOAD && addr_ok)
            shadow[iAddr] <= iWrDt;
         if (!iCsn && iWrn)
            oRdDt <= addr_ok ? shadow[iAddr] : '0;
         else
            oRdDt <= '0;
         if (commit)
            for (int i = 0; i < NUM_COEFF; i++) active[i] <= shadow[i];
      end
   end

   assign oCoeff1  = active[0];
   assign oCoeff2  = active[1];
   assign oCoeff3  = active[2];
   assign oCoeff4  = active[3];
   assign oCoeff5  = active[4];
   assign oCoeff6  = active[5];
   assign oCoeff7  = active[6];
   assign oCoeff8  = active[7];
   assign oCoeff9  = active[8];
   assign oCoeff10 = active[9];
   assign oBusy    = (state != IDLE);

endmodule
